// File: rtl/hp_au_issue.sv
// hp_au_issue: valid/ready command front-end that drives a combinational hp_au_top and returns its result.
// Optional statistics counters are enabled with `define HP_AU_ISSUE_STATS_EN.
`default_nettype none

module hp_au_issue #(
    parameter int WIDTH   = 4,
    parameter int SEL_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_sel,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic [3:0]       au_sel,
    input  logic [WIDTH-1:0] au_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic             busy
`ifdef HP_AU_ISSUE_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [7:0]       stat_errs
`endif
);

    localparam logic [3:0] SEL_MAX_CODE = 4'(SEL_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   op_err;

    wire req_fire   = req_valid && req_ready && (state == IDLE);
    wire rsp_fire   = rsp_valid && rsp_ready && (state == RESP);
    wire sel_illegal = (req_sel > SEL_MAX_CODE);

    // The operand registers are the AU port drivers; an illegal code parks sel at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            au_a       <= '0;
            au_b       <= '0;
            au_sel     <= '0;
            op_err     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        au_a      <= req_a;
                        au_b      <= req_b;
                        au_sel    <= sel_illegal ? 4'd0 : req_sel;
                        op_err    <= sel_illegal;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= EXEC;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_result <= op_err ? '0 : au_result;
                    rsp_err    <= op_err;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef HP_AU_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (rsp_fire) begin
            stat_ops <= stat_ops + 16'd1;
            if (rsp_err && (stat_errs != 8'hFF)) begin
                stat_errs <= stat_errs + 8'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hp_au_issue.sv
// Directed bench for hp_au_issue with a behavioural AU stub on the au_* ports.
`default_nettype none

module tb_hp_au_issue;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       req_sel;
    logic [WIDTH-1:0] au_a;
    logic [WIDTH-1:0] au_b;
    logic [3:0]       au_sel;
    logic [WIDTH-1:0] au_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_err;
    logic             busy;
`ifdef HP_AU_ISSUE_STATS_EN
    logic [15:0]      stat_ops;
    logic [7:0]       stat_errs;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hp_au_issue #(.WIDTH(WIDTH), .SEL_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .au_a       (au_a),
        .au_b       (au_b),
        .au_sel     (au_sel),
        .au_result  (au_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
`ifdef HP_AU_ISSUE_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_errs  (stat_errs)
`endif
    );

    // AU stub: AND and truncating MUL as mapped, ADD for any other code.
    logic [7:0] prod;
    always_comb begin
        prod = 8'(au_a) * 8'(au_b);
        case (au_sel)
            4'd4:    au_result = au_a & au_b;
            4'd8:    au_result = prod[WIDTH-1:0];
            default: au_result = au_a + au_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One op with rsp_ready held high: EXEC cycle, then RESP cycle, then back to IDLE.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                         input logic [3:0] exp_sel, input logic [3:0] exp_res, input logic exp_err);
        req_valid = 1'b1; req_a = a; req_b = b; req_sel = sel; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_a = 4'hF; req_b = 4'hF; req_sel = 4'hF;
        chk("exec_busy",      busy,      1);
        chk("exec_req_ready", req_ready, 0);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_au_a",      au_a,      a);
        chk("exec_au_b",      au_b,      b);
        chk("exec_au_sel",    au_sel,    exp_sel);
        @(negedge clk);
        chk("resp_valid",  rsp_valid,  1);
        chk("resp_result", rsp_result, exp_res);
        chk("resp_err",    rsp_err,    exp_err);
        @(negedge clk);
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_busy",      busy,      0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  req_ready,  0);
        chk("rst_rsp_valid",  rsp_valid,  0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_err",    rsp_err,    0);
        chk("rst_busy",       busy,       0);
        chk("rst_au_a",       au_a,       0);
        chk("rst_au_b",       au_b,       0);
        chk("rst_au_sel",     au_sel,     0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        do_op(4'b1100, 4'b1010, 4'd4, 4'd4, 4'b1000, 1'b0);
        do_op(4'd3, 4'd2, 4'd8, 4'd8, 4'd6, 1'b0);
        do_op(4'd4, 4'd4, 4'd8, 4'd8, 4'd0, 1'b0);
        do_op(4'd5, 4'd5, 4'd12, 4'd0, 4'd0, 1'b1);
`ifdef HP_AU_ISSUE_STATS_EN
        chk("stat_ops_4",  stat_ops,  4);
        chk("stat_errs_1", stat_errs, 1);
`endif

        // Backpressure with a second request waiting.
        req_valid = 1'b1; req_a = 4'd2; req_b = 4'd3; req_sel = 4'd8; rsp_ready = 1'b0;
        @(negedge clk);
        req_a = 4'd15; req_b = 4'd7; req_sel = 4'd4;
        chk("bp_exec_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid",  rsp_valid,  1);
            chk("bp_rsp_result", rsp_result, 6);
            chk("bp_req_ready",  req_ready,  0);
            chk("bp_au_a",       au_a,       2);
            @(negedge clk);
        end
        chk("bp_hold_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_rsp_valid", rsp_valid, 0);
        chk("bp_hs_req_ready", req_ready, 1);
        chk("bp_hs_au_a",      au_a,      2);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp2_busy",   busy,   1);
        chk("bp2_au_a",   au_a,   15);
        chk("bp2_au_sel", au_sel, 4);
        @(negedge clk);
        chk("bp2_rsp_valid",  rsp_valid,  1);
        chk("bp2_rsp_result", rsp_result, 7);
        @(negedge clk);
        chk("bp2_done", rsp_valid, 0);

        // Reset during EXEC discards the op.
        req_valid = 1'b1; req_a = 4'd1; req_b = 4'd1; req_sel = 4'd8; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rx_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rx_req_ready",  req_ready,  0);
        chk("rx_rsp_valid",  rsp_valid,  0);
        chk("rx_rsp_result", rsp_result, 0);
        chk("rx_rsp_err",    rsp_err,    0);
        chk("rx_busy_0",     busy,       0);
        chk("rx_au_a",       au_a,       0);
        chk("rx_au_sel",     au_sel,     0);
`ifdef HP_AU_ISSUE_STATS_EN
        chk("rx_stat_ops",  stat_ops,  0);
        chk("rx_stat_errs", stat_errs, 0);
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rx_no_rsp", rsp_valid, 0);
        end
        chk("rx_idle_ready", req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
